fft64_r4_ctrl: RTL and testbench
================================

Name: fft64_r4_ctrl

Overview:
- Sequencer for an in-place 64-point radix-4 FFT built around the 4-point butterfly core.
- On a start pulse it runs 3 stages of 16 butterfly issues each. Per issue it generates:
  - four read addresses for a 4-read/4-write data RAM;
  - a twiddle ROM index aligned to core input;
  - delayed write-back addresses and enable.
- Sits between the top-level FFT wrapper, the working RAM, the twiddle ROM and the butterfly datapath.
- Inserts a drain gap between stages so that no stage reads data the previous stage has not yet written.

Parameters:
- RD_LAT, 1, RAM read latency in cycles (>=1). Read data reaches the core RD_LAT cycles after rd_en_o.
- CORE_LAT, 1, butterfly-path latency in cycles (>=0), from core input to write-data valid.
- ADDR_WID, 6, RAM address width. Fixed for 64 points; changing it is not supported.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  one-cycle start request; honoured only in IDLE
- busy_o  out  1  high from the cycle after start is accepted until done_o
- done_o  out  1  one-cycle pulse after the final stage-2 write
- stage_o  out  2  current issue stage, 0..2 (0 in IDLE)
- rd_en_o  out  1  read issue strobe
- rd_addr_o  out  4*ADDR_WID  read addresses; lane k occupies bits [(k+1)*ADDR_WID-1 : k*ADDR_WID]
- tw_en_o  out  1  twiddle index valid; equals rd_en_o delayed RD_LAT cycles
- tw_idx_o  out  6  twiddle exponent index into the ROM; aligned with tw_en_o
- wr_en_o  out  1  write-back strobe; equals rd_en_o delayed L = RD_LAT + CORE_LAT cycles
- wr_addr_o  out  4*ADDR_WID  write addresses; equal rd_addr_o delayed L cycles, same lane order

Behaviour:
- Reset (rst_i high at a clock edge):
  - state = IDLE;
  - all outputs 0, including busy_o, done_o, stage_o, rd_en_o, tw_en_o, wr_en_o, all address buses and tw_idx_o;
  - all delay-line valid bits cleared.
  - Reset mid-run aborts immediately: no further rd_en_o or wr_en_o and no done_o.
- States:
  - IDLE: waits for start_i.
  - ISSUE: 16 issue cycles.
  - DRAIN: L cycles with no issue.
  - FINISH: one cycle.
- Transitions:
  - IDLE --start_i--> ISSUE (stage 0, g = 0).
  - ISSUE --g==15--> DRAIN.
  - DRAIN --drain count done, stage<2--> ISSUE (stage+1, g = 0).
  - DRAIN --drain count done, stage==2--> FINISH.
  - FINISH --> IDLE.
- done_o is asserted in FINISH.
- start_i while not in IDLE is ignored, with no side effects.
- Issue timing:
  - start_i sampled at cycle 0 gives the first rd_en_o at cycle 1.
  - Stage s issues on cycles 1 + s*(16+L) through 16 + s*(16+L), one butterfly per cycle, no bubbles.
  - The last write of a stage occurs at its last issue + L. The next stage's first read is one cycle later, since RAM write-to-read visibility is one cycle.
  - done_o is asserted at cycle 49 + 3L. With defaults (L = 2) this is cycle 55.
  - busy_o is high from cycle 1 through cycle 49 + 3L inclusive.
- Address generation, with g = group 0..15 and stride = 16, 4, 1 for stages 0, 1, 2:
  - block = g / stride, off = g % stride;
  - base = block*4*stride + off;
  - lane k address = base + k*stride, for k = 0..3.
  - All arithmetic is unsigned, 6-bit. No overflow occurs by construction.
- Twiddle index: tw_idx = off * 4^s, i.e. off*1, off*4, off*16, mod 64. It is captured at issue and delayed RD_LAT cycles.
- Delay lines are shift registers carrying valid, addresses and twiddle index. Depth is RD_LAT for the twiddle line and L for the write line.
- stage_o follows the issuing stage and holds its value through DRAIN.
- Output ordering is natural-in / digit-reversed-out. Reordering is outside this block.

Decomposition:
- Shared package/include (fft_defines): FFT_N = 64, FFT_STAGES = 3, ADDR_WID = 6, state encodings, stride table.
- One sub-module: fft_dly_line, a parameterised-depth, parameterised-width shift register with synchronous clear on rst_i. It is instantiated for the twiddle path and the write-back path.

Test Plan:
- Reset then start_i at cycle 0, defaults:
  - rd_en_o high on cycles 1–16, 19–34 and 37–52;
  - wr_en_o high on cycles 3–18, 21–36 and 39–54;
  - done_o high on cycle 55 only;
  - busy_o high on cycles 1–55.
- Address/twiddle check, g = 5:
  - stage 0: rd_addr = {5, 21, 37, 53}, tw_idx = 5;
  - stage 1: rd_addr = {17, 21, 25, 29}, tw_idx = 4;
  - stage 2: rd_addr = {20, 21, 22, 23}, tw_idx = 0.
  - wr_addr_o reproduces each set exactly 2 cycles later.
- Coverage scoreboard: within each stage the union of all 64 read addresses is exactly {0..63} with no duplicates. Every wr_en_o of stage s precedes the first rd_en_o of stage s+1.
- start_i pulsed on cycles 10 and 40 during a run:
  - no restart and no timing change;
  - a single done_o at cycle 55.
- rst_i asserted at cycle 25:
  - from cycle 26, all outputs are 0 and no wr_en_o occurs;
  - a new start_i at cycle 30 yields the first rd_en_o at cycle 31 with stage 0 addresses.
- RD_LAT = 2, CORE_LAT = 3 (L = 5):
  - wr_en_o lags rd_en_o by 5 cycles;
  - tw_en_o lags rd_en_o by 2 cycles;
  - done_o at cycle 64.

Source files
------------

// File: rtl/fft64_r4_ctrl_pkg.sv
// Shared constants, FSM encoding, delay-line payloads and the radix-4 address/twiddle helpers
// for the 64-point FFT sequencer.
package fft64_r4_ctrl_pkg;

  localparam int unsigned FFT_N      = 64;
  localparam int unsigned FFT_STAGES = 3;
  localparam int unsigned ADDR_WID   = 6;
  localparam int unsigned LANES      = 4;
  localparam int unsigned GRP_W      = 4;
  localparam int unsigned TW_W       = 6;
  localparam int unsigned BUS_W      = LANES * ADDR_WID;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_DRAIN  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  typedef struct packed {
    logic            vld;
    logic [TW_W-1:0] idx;
  } tw_pld_t;

  typedef struct packed {
    logic             vld;
    logic [BUS_W-1:0] addr;
  } wr_pld_t;

  // Stride per stage is 16, 4, 1; the shift is its log2.
  function automatic logic [2:0] stride_sh(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd4;
      2'd1:    return 3'd2;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [BUS_W-1:0] lane_addrs(input logic [1:0] s, input logic [GRP_W-1:0] g);
    logic [2:0]          sh;
    logic [ADDR_WID-1:0] st, blk, off, base;
    logic [BUS_W-1:0]    a;
    sh   = stride_sh(s);
    st   = ADDR_WID'(1) << sh;
    blk  = ADDR_WID'(g) >> sh;
    off  = ADDR_WID'(g) & (st - ADDR_WID'(1));
    base = (blk << (sh + 3'd2)) + off;
    a    = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      a[k*ADDR_WID +: ADDR_WID] = base + st * ADDR_WID'(k);
    end
    return a;
  endfunction

  // Twiddle exponent is off * 4^s, wrapping mod 64.
  function automatic logic [TW_W-1:0] tw_index(input logic [1:0] s, input logic [GRP_W-1:0] g);
    logic [2:0]      sh;
    logic [TW_W-1:0] off;
    sh  = stride_sh(s);
    off = TW_W'(g) & ((TW_W'(1) << sh) - TW_W'(1));
    return off << {s, 1'b0};
  endfunction

endpackage

// File: rtl/fft64_r4_ctrl_if.sv
// Control/address bundle between the FFT sequencer and the wrapper, RAM, ROM and butterfly core.
interface fft64_r4_ctrl_if;
  import fft64_r4_ctrl_pkg::*;

  logic             start_i;
  logic             busy_o;
  logic             done_o;
  logic [1:0]       stage_o;
  logic             rd_en_o;
  logic [BUS_W-1:0] rd_addr_o;
  logic             tw_en_o;
  logic [TW_W-1:0]  tw_idx_o;
  logic             wr_en_o;
  logic [BUS_W-1:0] wr_addr_o;

  modport master (
    input  start_i,
    output busy_o, done_o, stage_o, rd_en_o, rd_addr_o,
    output tw_en_o, tw_idx_o, wr_en_o, wr_addr_o
  );

  modport slave (
    output start_i,
    input  busy_o, done_o, stage_o, rd_en_o, rd_addr_o,
    input  tw_en_o, tw_idx_o, wr_en_o, wr_addr_o
  );
endinterface

// File: rtl/fft64_r4_ctrl_dly_line.sv
// Fixed-depth shift register with synchronous clear; aligns issue-time data to later pipeline points.
module fft_dly_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] r_sr [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign q_o = r_sr[DEPTH-1];

endmodule

// File: rtl/fft64_r4_ctrl.sv
// In-place 64-point radix-4 FFT sequencer: 3 stages x 16 butterfly issues with a drain gap
// between stages; read, twiddle and write-back streams are aligned to RAM and core latency.
module fft64_r4_ctrl
  import fft64_r4_ctrl_pkg::*;
#(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned CORE_LAT = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  fft64_r4_ctrl_if.master  bus
);

  localparam int unsigned L     = RD_LAT + CORE_LAT;
  localparam int unsigned CNT_W = $clog2(L + 1);

  state_t           r_state;
  logic [1:0]       r_stage;
  logic [GRP_W-1:0] r_grp;
  logic [CNT_W-1:0] r_drain;
  logic             r_busy, r_done, r_rd_en;
  logic [1:0]       r_stage_o;
  logic [BUS_W-1:0] r_rd_addr;
  logic [TW_W-1:0]  r_tw_idx;

  tw_pld_t w_tw_in, w_tw_out;
  wr_pld_t w_wr_in, w_wr_out;

  // Outputs are registered decodes of the state, so issue trails the start edge by one cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= S_IDLE;
      r_stage   <= '0;
      r_grp     <= '0;
      r_drain   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_stage_o <= '0;
      r_rd_addr <= '0;
      r_tw_idx  <= '0;
    end else begin
      r_busy    <= (r_state != S_IDLE);
      r_done    <= (r_state == S_FINISH);
      r_rd_en   <= (r_state == S_ISSUE);
      r_stage_o <= (r_state == S_IDLE) ? 2'd0 : r_stage;
      r_rd_addr <= (r_state == S_ISSUE) ? lane_addrs(r_stage, r_grp) : '0;
      r_tw_idx  <= (r_state == S_ISSUE) ? tw_index(r_stage, r_grp) : '0;

      case (r_state)
        S_IDLE: begin
          if (bus.start_i) begin
            r_state <= S_ISSUE;
            r_stage <= 2'd0;
            r_grp   <= '0;
          end
        end
        S_ISSUE: begin
          r_grp <= r_grp + GRP_W'(1);
          if (r_grp == GRP_W'(15)) begin
            r_state <= S_DRAIN;
            r_drain <= '0;
          end
        end
        S_DRAIN: begin
          // Hold off the next stage until the last write of this one is visible.
          if (r_drain == CNT_W'(L - 1)) begin
            if (r_stage == 2'(FFT_STAGES - 1)) begin
              r_state <= S_FINISH;
            end else begin
              r_state <= S_ISSUE;
              r_stage <= r_stage + 2'd1;
              r_grp   <= '0;
            end
          end else begin
            r_drain <= r_drain + CNT_W'(1);
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_stage <= 2'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_tw_in = '{vld: r_rd_en, idx: r_tw_idx};
  assign w_wr_in = '{vld: r_rd_en, addr: r_rd_addr};

  fft_dly_line #(.DEPTH(RD_LAT), .WIDTH($bits(tw_pld_t))) u_tw_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (w_tw_in),
    .q_o   (w_tw_out)
  );

  fft_dly_line #(.DEPTH(L), .WIDTH($bits(wr_pld_t))) u_wr_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (w_wr_in),
    .q_o   (w_wr_out)
  );

  assign bus.busy_o    = r_busy;
  assign bus.done_o    = r_done;
  assign bus.stage_o   = r_stage_o;
  assign bus.rd_en_o   = r_rd_en;
  assign bus.rd_addr_o = r_rd_addr;
  assign bus.tw_en_o   = w_tw_out.vld;
  assign bus.tw_idx_o  = w_tw_out.idx;
  assign bus.wr_en_o   = w_wr_out.vld;
  assign bus.wr_addr_o = w_wr_out.addr;

endmodule

// File: tb/tb_fft64_r4_ctrl.sv
// Directed bench for fft64_r4_ctrl: default latencies (L=2) on dut_a and RD_LAT=2/CORE_LAT=3 on dut_b.
module tb_fft64_r4_ctrl;
  import fft64_r4_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  fft64_r4_ctrl_if bus_a ();
  fft64_r4_ctrl_if bus_b ();

  fft64_r4_ctrl #(.RD_LAT(1), .CORE_LAT(1)) dut_a (.clk_i(clk), .rst_i(rst_a), .bus(bus_a));
  fft64_r4_ctrl #(.RD_LAT(2), .CORE_LAT(3)) dut_b (.clk_i(clk), .rst_i(rst_b), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  // Hand-computed g=5 vectors per stage, lane 0 in the low bits.
  localparam logic [23:0] EXP_G5 [3] = '{{6'd53, 6'd37, 6'd21, 6'd5},
                                         {6'd29, 6'd25, 6'd21, 6'd17},
                                         {6'd23, 6'd22, 6'd21, 6'd20}};
  localparam logic [5:0]  EXP_TW5 [3] = '{6'd5, 6'd4, 6'd0};
  localparam logic [23:0] EXP_G0_S0 = {6'd48, 6'd32, 6'd16, 6'd0};

  task automatic chk(input string tag, input int c, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue window of stage s is 1+s*(16+l) .. 16+s*(16+l), counted from the start edge.
  function automatic logic exp_rd(input int c, input int l);
    for (int s = 0; s < 3; s++)
      if (c >= 1 + s*(16+l) && c <= 16 + s*(16+l)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic zero_a(input int c);
    chk("z_busy", c, 32'(bus_a.busy_o), 0);
    chk("z_done", c, 32'(bus_a.done_o), 0);
    chk("z_stage", c, 32'(bus_a.stage_o), 0);
    chk("z_rd_en", c, 32'(bus_a.rd_en_o), 0);
    chk("z_rd_addr", c, 32'(bus_a.rd_addr_o), 0);
    chk("z_tw_en", c, 32'(bus_a.tw_en_o), 0);
    chk("z_tw_idx", c, 32'(bus_a.tw_idx_o), 0);
    chk("z_wr_en", c, 32'(bus_a.wr_en_o), 0);
    chk("z_wr_addr", c, 32'(bus_a.wr_addr_o), 0);
  endtask

  // Full run on dut_a after the start edge (cycle 0); optional stray start pulses at 10 and 40.
  task automatic run_a(input bit pulse);
    bit seen [3][64];
    int dup, cnt, s, ndone;
    int first_rd [3];
    int last_wr [3];
    logic [5:0] a;
    dup = 0; ndone = 0;
    for (int i = 0; i < 3; i++) begin
      first_rd[i] = -1; last_wr[i] = -1;
      for (int j = 0; j < 64; j++) seen[i][j] = 1'b0;
    end
    for (int c = 1; c <= 60; c++) begin
      bus_a.start_i = pulse && (c == 10 || c == 40);
      tick();
      bus_a.start_i = 1'b0;
      chk("rd_en", c, 32'(bus_a.rd_en_o), 32'(exp_rd(c, 2)));
      chk("wr_en", c, 32'(bus_a.wr_en_o), 32'(exp_rd(c - 2, 2)));
      chk("tw_en", c, 32'(bus_a.tw_en_o), 32'(exp_rd(c - 1, 2)));
      chk("done", c, 32'(bus_a.done_o), 32'(c == 55));
      chk("busy", c, 32'(bus_a.busy_o), 32'(c >= 1 && c <= 55));
      if (bus_a.done_o) ndone++;
      if (bus_a.rd_en_o) begin
        s = (c - 1) / 18;
        if (s < 3) begin
          chk("stage", c, 32'(bus_a.stage_o), 32'(s));
          if (first_rd[s] < 0) first_rd[s] = c;
          for (int k = 0; k < 4; k++) begin
            a = bus_a.rd_addr_o[k*6 +: 6];
            if (seen[s][a]) dup++;
            seen[s][a] = 1'b1;
          end
        end
      end
      if (bus_a.wr_en_o) begin
        s = (c - 3) / 18;
        if (s < 3) last_wr[s] = c;
      end
      for (int t = 0; t < 3; t++) begin
        if (c == 6 + t*18) chk("rd_addr_g5", c, 32'(bus_a.rd_addr_o), 32'(EXP_G5[t]));
        if (c == 7 + t*18) chk("tw_idx_g5", c, 32'(bus_a.tw_idx_o), 32'(EXP_TW5[t]));
        if (c == 8 + t*18) chk("wr_addr_g5", c, 32'(bus_a.wr_addr_o), 32'(EXP_G5[t]));
      end
    end
    chk("done_count", 60, 32'(ndone), 1);
    chk("dup_addrs", 60, 32'(dup), 0);
    for (int t = 0; t < 3; t++) begin
      cnt = 0;
      for (int j = 0; j < 64; j++) if (seen[t][j]) cnt++;
      chk("cover", t, 32'(cnt), 64);
    end
    for (int t = 0; t < 2; t++)
      chk("wr_before_rd", t, 32'(last_wr[t] >= 0 && last_wr[t] < first_rd[t+1]), 1);
  endtask

  initial begin
    int ndone, dcyc;
    rst_a = 1'b1; rst_b = 1'b1;
    bus_a.start_i = 1'b0; bus_b.start_i = 1'b0;
    repeat (3) tick();
    zero_a(-1);
    chk("b_rst_busy", -1, 32'(bus_b.busy_o), 0);
    chk("b_rst_wr_en", -1, 32'(bus_b.wr_en_o), 0);
    chk("b_rst_tw_en", -1, 32'(bus_b.tw_en_o), 0);
    rst_a = 1'b0; rst_b = 1'b0;
    tick();

    // Clean run with defaults.
    bus_a.start_i = 1'b1;
    tick();
    bus_a.start_i = 1'b0;
    chk("c0_rd_en", 0, 32'(bus_a.rd_en_o), 0);
    chk("c0_busy", 0, 32'(bus_a.busy_o), 0);
    run_a(1'b0);
    tick();
    chk("idle_stage", 61, 32'(bus_a.stage_o), 0);

    // Run with start pulses mid-flight.
    bus_a.start_i = 1'b1;
    tick();
    bus_a.start_i = 1'b0;
    run_a(1'b1);
    tick();

    // Reset at cycle 25, restart at cycle 30.
    bus_a.start_i = 1'b1;
    tick();
    bus_a.start_i = 1'b0;
    repeat (24) tick();
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    for (int c = 26; c <= 30; c++) begin
      bus_a.start_i = (c == 30);
      tick();
      bus_a.start_i = 1'b0;
      zero_a(c);
    end
    tick();
    chk("rs_rd_en", 31, 32'(bus_a.rd_en_o), 1);
    chk("rs_rd_addr", 31, 32'(bus_a.rd_addr_o), 32'(EXP_G0_S0));
    chk("rs_stage", 31, 32'(bus_a.stage_o), 0);
    chk("rs_busy", 31, 32'(bus_a.busy_o), 1);
    ndone = 0; dcyc = -1;
    for (int c = 32; c <= 95; c++) begin
      tick();
      if (bus_a.done_o) begin ndone++; dcyc = c; end
    end
    chk("rs_done_count", 95, 32'(ndone), 1);
    chk("rs_done_cycle", 95, 32'(dcyc), 85);

    // Long-latency instance, L = 5.
    bus_b.start_i = 1'b1;
    tick();
    bus_b.start_i = 1'b0;
    for (int c = 1; c <= 70; c++) begin
      tick();
      chk("b_rd_en", c, 32'(bus_b.rd_en_o), 32'(exp_rd(c, 5)));
      chk("b_wr_en", c, 32'(bus_b.wr_en_o), 32'(exp_rd(c - 5, 5)));
      chk("b_tw_en", c, 32'(bus_b.tw_en_o), 32'(exp_rd(c - 2, 5)));
      chk("b_done", c, 32'(bus_b.done_o), 32'(c == 64));
      chk("b_busy", c, 32'(bus_b.busy_o), 32'(c >= 1 && c <= 64));
      if (c == 8)  chk("b_tw_idx_g5", c, 32'(bus_b.tw_idx_o), 32'(EXP_TW5[0]));
      if (c == 11) chk("b_wr_addr_g5", c, 32'(bus_b.wr_addr_o), 32'(EXP_G5[0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
